camera_reg_config: RTL and testbench
====================================

# camera_reg_config

Register-table sequencer that programs the camera sensor over SCCB once the power-up sequence completes. Sits directly downstream of the camera power-on delay stage: it waits for `initial_en`, walks a synchronous register lookup table entry by entry, and hands each 24-bit entry to the I2C/SCCB write controller through a req/ack handshake. It inserts a settle delay after the sensor soft-reset write, retries failed writes, and reports completion or failure to the capture path.

## Interface
- `LUT_SIZE`, 250: number of table entries, indices 0..LUT_SIZE-1; must be at least 1.
- `IDX_W`, 9: width of `lut_index`; requires 2^IDX_W ≥ LUT_SIZE.
- `DELAY_CYC`, 120000: settle cycles after a soft-reset write (5 ms at 24 MHz).
- `MAX_RETRY`, 3: extra attempts allowed per entry after an error ack.
- `clk_24M` input 1: the single clock for the block.
- `reset_n` input 1: asynchronous, active-low reset.
- `initial_en` input 1: level signal from the power-on stage; high means the sensor is ready for SCCB.
- `lut_index` output IDX_W: table read address.
- `lut_data` input 24: table entry {reg_addr[15:0], reg_data[7:0]}; valid 1 cycle after `lut_index` changes.
- `i2c_req` output 1: write request to the SCCB controller.
- `i2c_data` output 24: entry being written; stable while `i2c_req`=1.
- `i2c_ack` input 1: single-cycle completion pulse from the controller.
- `i2c_err` input 1: qualified by `i2c_ack`; 1 means NACK or failed write.
- `config_done` output 1: sticky flag; all entries written successfully.
- `config_err` output 1: sticky flag; an entry exhausted its retries.

## Operation
- States: IDLE, FETCH, WAIT_ACK, DELAY, NEXT, DONE, FAIL.
- IDLE: `lut_index`=0 and retry counter=0. If `initial_en` is sampled 1, go to FETCH.
- FETCH: one cycle to cover the LUT read latency. On exit, register `i2c_data`←`lut_data`, set `i2c_req`←1, go to WAIT_ACK.
- WAIT_ACK: hold `i2c_req` and `i2c_data` constant.
  - On `i2c_ack`&!`i2c_err`: drop `i2c_req` and clear the retry counter. If `i2c_data`[23:8]==16'h3008 and `i2c_data`[7]==1 (soft reset), go to DELAY; otherwise go to NEXT.
  - On `i2c_ack`&`i2c_err`: drop `i2c_req`. If retry counter < MAX_RETRY, increment it and go to FETCH, which re-requests the same index. Otherwise go to FAIL.
  - `i2c_ack` is ignored in every other state.
- DELAY: load the counter with DELAY_CYC-1 on entry and count down to 0, then go to NEXT. The state lasts exactly DELAY_CYC cycles.
- NEXT: if `lut_index`==LUT_SIZE-1, go to DONE. Otherwise increment `lut_index` and go to FETCH.
- DONE: `config_done`=1. FAIL: `config_err`=1. Both states are terminal until exit.
- `initial_en` sampled 0 in any state: synchronous abort to IDLE.
  - In the same edge: `i2c_req`←0, `lut_index`←0, `config_done`←0, `config_err`←0, counters cleared.
  - A late `i2c_ack` arriving after the abort is ignored.
- Arithmetic: `lut_index` never exceeds LUT_SIZE-1 and never wraps. The retry counter is ceil(log2(MAX_RETRY+1)) bits wide and saturates at MAX_RETRY. The delay counter is ≥17 bits wide.

## Timing
- Reset (async assert, sync release): all outputs 0 (`lut_index`=0, `i2c_req`=0, `i2c_data`=0, `config_done`=0, `config_err`=0); state is IDLE.
- `initial_en` sampled 1 at edge N: state=FETCH after N. `i2c_req`=1 and `i2c_data`=entry 0 after edge N+1.
- Ack at edge M: `i2c_req`=0 after M. Without a delay, the next `i2c_req` rises after M+2 (NEXT, then FETCH).
- Soft-reset entry acked at edge M: DELAY for DELAY_CYC cycles. The next `i2c_req` rises after M+DELAY_CYC+2.
- Retry: `i2c_req` rises again after M+1, carrying identical `i2c_data`.
- Final ack at edge M: `config_done`=1 after M+1.
- Minimum gap between requests: `i2c_req` is low for at least 1 cycle between consecutive requests.
- `i2c_ack` and an `initial_en` fall in the same cycle: the abort wins.

## Test plan
- Reset/idle: LUT_SIZE=4, hold `initial_en`=0 for 100 cycles -> all outputs remain 0, `i2c_req` never rises.
- Normal run: LUT_SIZE=4, 4 non-reset entries, controller acks 5 cycles after each req -> 4 requests with `i2c_data` equal to entries 0..3 in order, `config_done`=1 one cycle after the 4th ack, `lut_index`=3.
- Soft-reset delay: entry 1 = 24'h300882, DELAY_CYC=10 -> `i2c_req` for entry 2 rises exactly 12 cycles after entry 1's ack.
- Retry then success: MAX_RETRY=2, entry 0 acked with `i2c_err`=1 twice, then clean -> 3 requests carrying the same `i2c_data`, sequence continues to `config_done`=1, `config_err`=0.
- Retry exhaustion: MAX_RETRY=2, every ack on entry 2 has `i2c_err`=1 -> exactly 3 requests for entry 2, then `config_err`=1, `config_done`=0, no further requests.
- Abort mid-run: drop `initial_en` while in WAIT_ACK on entry 1, then raise it 20 cycles later -> `i2c_req`=0 on the next edge, `lut_index`=0, and the restarted sequence issues entry 0 again.

Source files
------------

// File: rtl/camera_reg_config.sv
// rtl/camera_reg_config.sv - sequences a register LUT into SCCB writes with soft-reset settle and retry
module camera_reg_config #(
    parameter int LUT_SIZE  = 250,
    parameter int IDX_W     = 9,
    parameter int DELAY_CYC = 120000,
    parameter int MAX_RETRY = 3
) (
    input  logic             clk_24M,
    input  logic             reset_n,
    input  logic             initial_en,
    output logic [IDX_W-1:0] lut_index,
    input  logic [23:0]      lut_data,
    output logic             i2c_req,
    output logic [23:0]      i2c_data,
    input  logic             i2c_ack,
    input  logic             i2c_err,
    output logic             config_done,
    output logic             config_err
);

    localparam int RTY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam int DLY_W = ($clog2(DELAY_CYC) > 17) ? $clog2(DELAY_CYC) : 17;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LUT_SIZE - 1);
    localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);
    localparam logic [DLY_W-1:0] DLY_LOAD = DLY_W'(DELAY_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT_ACK,
        S_DELAY,
        S_NEXT,
        S_DONE,
        S_FAIL
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [RTY_W-1:0] retry_cnt;
    logic [DLY_W-1:0] dly_cnt;

    logic ack_ok;
    logic ack_bad;
    logic soft_rst;
    logic at_last;
    logic can_retry;
    logic dly_zero;

    assign ack_ok    = i2c_ack & ~i2c_err;
    assign ack_bad   = i2c_ack & i2c_err;
    assign soft_rst  = (i2c_data[23:8] == 16'h3008) && i2c_data[7];
    assign at_last   = (lut_index == LAST_IDX);
    assign can_retry = (retry_cnt < RTY_MAX);
    assign dly_zero  = (dly_cnt == '0);

    always_ff @(posedge clk_24M or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Dropping initial_en aborts from any state, ahead of any ack in the same cycle.
    always_comb begin
        state_nxt = state;
        if (!initial_en) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:     state_nxt = S_FETCH;
                S_FETCH:    state_nxt = S_WAIT_ACK;
                S_WAIT_ACK: begin
                    if (ack_ok) begin
                        state_nxt = soft_rst ? S_DELAY : S_NEXT;
                    end else if (ack_bad) begin
                        state_nxt = can_retry ? S_FETCH : S_FAIL;
                    end
                end
                S_DELAY:    if (dly_zero) state_nxt = S_NEXT;
                S_NEXT:     state_nxt = at_last ? S_DONE : S_FETCH;
                S_DONE:     state_nxt = S_DONE;
                S_FAIL:     state_nxt = S_FAIL;
                default:    state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_24M or negedge reset_n) begin
        if (!reset_n) begin
            lut_index   <= '0;
            i2c_req     <= 1'b0;
            i2c_data    <= '0;
            config_done <= 1'b0;
            config_err  <= 1'b0;
            retry_cnt   <= '0;
            dly_cnt     <= '0;
        end else if (!initial_en) begin
            lut_index   <= '0;
            i2c_req     <= 1'b0;
            config_done <= 1'b0;
            config_err  <= 1'b0;
            retry_cnt   <= '0;
            dly_cnt     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    lut_index <= '0;
                    retry_cnt <= '0;
                end
                S_FETCH: begin
                    i2c_data <= lut_data;
                    i2c_req  <= 1'b1;
                end
                S_WAIT_ACK: begin
                    if (i2c_ack) begin
                        i2c_req <= 1'b0;
                        if (!i2c_err) begin
                            retry_cnt <= '0;
                            if (soft_rst) dly_cnt <= DLY_LOAD;
                        end else if (can_retry) begin
                            retry_cnt <= retry_cnt + RTY_W'(1);
                        end else begin
                            config_err <= 1'b1;
                        end
                    end
                end
                S_DELAY: begin
                    if (!dly_zero) dly_cnt <= dly_cnt - DLY_W'(1);
                end
                S_NEXT: begin
                    if (at_last) begin
                        config_done <= 1'b1;
                    end else begin
                        lut_index <= lut_index + IDX_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_camera_reg_config.sv
// tb/tb_camera_reg_config.sv - scoreboard bench for camera_reg_config with a small LUT and fast settle
module tb_camera_reg_config;

    localparam int LUT_SIZE  = 4;
    localparam int IDX_W     = 2;
    localparam int DELAY_CYC = 10;
    localparam int MAX_RETRY = 2;
    localparam int ACK_DLY   = 5;

    logic             clk_24M = 1'b0;
    logic             reset_n;
    logic             initial_en;
    logic [IDX_W-1:0] lut_index;
    logic [23:0]      lut_data;
    logic             i2c_req;
    logic [23:0]      i2c_data;
    logic             i2c_ack;
    logic             i2c_err;
    logic             config_done;
    logic             config_err;

    logic [23:0] rom [LUT_SIZE];
    assign lut_data = rom[lut_index];

    camera_reg_config #(
        .LUT_SIZE (LUT_SIZE),
        .IDX_W    (IDX_W),
        .DELAY_CYC(DELAY_CYC),
        .MAX_RETRY(MAX_RETRY)
    ) dut (
        .clk_24M    (clk_24M),
        .reset_n    (reset_n),
        .initial_en (initial_en),
        .lut_index  (lut_index),
        .lut_data   (lut_data),
        .i2c_req    (i2c_req),
        .i2c_data   (i2c_data),
        .i2c_ack    (i2c_ack),
        .i2c_err    (i2c_err),
        .config_done(config_done),
        .config_err (config_err)
    );

    always #5 clk_24M = ~clk_24M;

    typedef struct {
        logic [23:0] data;
        int          gap;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   errors   = 0;
    int   cyc      = 0;
    int   last_ack = 0;
    int   req_seen = 0;
    int   err_left [LUT_SIZE];
    bit   force_ack = 1'b0;

    logic             mon_prev_req  = 1'b0;
    logic [23:0]      mon_prev_data = '0;
    exp_t             mon_e;
    logic [IDX_W-1:0] r_idx;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_req(input logic [23:0] d, input int g);
        exp_t e;
        e.data = d;
        e.gap  = g;
        exp_q.push_back(e);
    endtask

    // gap = cycles from the previous ack edge to the edge where i2c_req rose; -1 means unchecked
    initial begin
        forever begin
            @(posedge clk_24M);
            cyc++;
            if (i2c_ack) last_ack = cyc;
        end
    end

    initial begin
        forever begin
            @(negedge clk_24M);
            if (i2c_req && mon_prev_req) check("data_stable", i2c_data, mon_prev_data);
            if (i2c_req && !mon_prev_req) begin
                req_seen++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_req: got data %0h, expected no request", i2c_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("req_data", i2c_data, mon_e.data);
                    if (mon_e.gap >= 0) check("req_gap", cyc - last_ack, mon_e.gap);
                end
            end
            mon_prev_req  = i2c_req;
            mon_prev_data = i2c_data;
        end
    end

    initial begin
        i2c_ack = 1'b0;
        i2c_err = 1'b0;
        forever begin
            @(negedge clk_24M);
            if (i2c_req) begin
                r_idx = lut_index;
                repeat (ACK_DLY - 1) @(negedge clk_24M);
                if (i2c_req || force_ack) begin
                    i2c_ack = 1'b1;
                    i2c_err = (err_left[r_idx] > 0);
                    if (i2c_err) err_left[r_idx]--;
                    @(negedge clk_24M);
                    i2c_ack = 1'b0;
                    i2c_err = 1'b0;
                end
            end
        end
    end

    task automatic wait_flag(input bit want_err, input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_24M);
            if (want_err ? config_err : config_done) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL wait_%s: got flag low after %0d cycles, expected high", want_err ? "err" : "done", budget);
        end
    endtask

    task automatic stop_run();
        @(negedge clk_24M);
        initial_en = 1'b0;
        repeat (3) @(negedge clk_24M);
        check("stop_done", config_done, 0);
        check("stop_err", config_err, 0);
        check("stop_index", lut_index, 0);
        check("queue_drained", exp_q.size(), 0);
        exp_q.delete();
        for (int i = 0; i < LUT_SIZE; i++) err_left[i] = 0;
        force_ack = 1'b0;
    endtask

    task automatic load_rom(input logic [23:0] a, input logic [23:0] b,
                            input logic [23:0] c, input logic [23:0] d);
        rom[0] = a;
        rom[1] = b;
        rom[2] = c;
        rom[3] = d;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish by time limit, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        bit  hit;
        reset_n    = 1'b0;
        initial_en = 1'b0;
        for (int i = 0; i < LUT_SIZE; i++) err_left[i] = 0;
        load_rom(24'h0A0B01, 24'h120034, 24'h300801, 24'h40FF55);
        repeat (3) @(negedge clk_24M);
        reset_n = 1'b1;
        @(negedge clk_24M);

        check("rst_index", lut_index, 0);
        check("rst_req", i2c_req, 0);
        check("rst_data", i2c_data, 0);
        check("rst_done", config_done, 0);
        check("rst_err", config_err, 0);
        repeat (100) @(negedge clk_24M);
        check("idle_no_req", req_seen, 0);
        check("idle_done", config_done, 0);

        // Normal run; 24'h300801 has bit 7 clear so it must not trigger the settle delay
        expect_req(24'h0A0B01, -1);
        expect_req(24'h120034, 2);
        expect_req(24'h300801, 2);
        expect_req(24'h40FF55, 2);
        initial_en = 1'b1;
        wait_flag(1'b0, 300);
        check("done_latency", cyc - last_ack, 1);
        check("done_index", lut_index, 3);
        check("done_no_err", config_err, 0);
        stop_run();

        load_rom(24'h111111, 24'h300882, 24'h300802, 24'h2A2A2A);
        expect_req(24'h111111, -1);
        expect_req(24'h300882, 2);
        expect_req(24'h300802, DELAY_CYC + 2);
        expect_req(24'h2A2A2A, 2);
        initial_en = 1'b1;
        wait_flag(1'b0, 300);
        check("sr_done_index", lut_index, 3);
        stop_run();

        load_rom(24'h0A0B01, 24'h120034, 24'h300801, 24'h40FF55);
        err_left[0] = 2;
        expect_req(24'h0A0B01, -1);
        expect_req(24'h0A0B01, 1);
        expect_req(24'h0A0B01, 1);
        expect_req(24'h120034, 2);
        expect_req(24'h300801, 2);
        expect_req(24'h40FF55, 2);
        initial_en = 1'b1;
        wait_flag(1'b0, 400);
        check("retry_no_err", config_err, 0);
        stop_run();

        err_left[2] = 3;
        expect_req(24'h0A0B01, -1);
        expect_req(24'h120034, 2);
        expect_req(24'h300801, 2);
        expect_req(24'h300801, 1);
        expect_req(24'h300801, 1);
        initial_en = 1'b1;
        wait_flag(1'b1, 400);
        check("fail_latency", cyc - last_ack, 0);
        check("fail_no_done", config_done, 0);
        n = req_seen;
        repeat (30) @(negedge clk_24M);
        check("fail_no_more_req", req_seen - n, 0);
        check("fail_index", lut_index, 2);
        check("fail_sticky", config_err, 1);
        stop_run();

        // Abort while waiting on entry 1; the responder still fires a late ack that must be ignored
        force_ack = 1'b1;
        expect_req(24'h0A0B01, -1);
        expect_req(24'h120034, 2);
        initial_en = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_24M);
            if (i2c_req && lut_index == 2'd1) begin
                hit = 1'b1;
                break;
            end
        end
        check("abort_reached", hit, 1);
        initial_en = 1'b0;
        @(posedge clk_24M);
        #1;
        check("abort_req", i2c_req, 0);
        check("abort_index", lut_index, 0);
        repeat (20) @(negedge clk_24M);
        check("abort_idle_req", i2c_req, 0);
        check("abort_idle_done", config_done, 0);
        check("abort_idle_err", config_err, 0);
        check("abort_queue", exp_q.size(), 0);
        force_ack = 1'b0;
        expect_req(24'h0A0B01, -1);
        expect_req(24'h120034, 2);
        expect_req(24'h300801, 2);
        expect_req(24'h40FF55, 2);
        initial_en = 1'b1;
        wait_flag(1'b0, 300);
        check("restart_index", lut_index, 3);
        stop_run();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
